// File: rtl/decode_regread_stage.sv
// Decode/register-read stage: decodes RV64I, reads operands with writeback forwarding,
// stalls on scoreboard hazards and registers a bundle toward execute.
module decode_regread_stage #(
  parameter int ADDRESS_WIDTH     = 64,
  parameter int REGISTER_WIDTH    = 64,
  parameter int REGISTERNO_WIDTH  = 5,
  parameter int INSTRUCTION_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         out_ready,
  input  logic [INSTRUCTION_WIDTH-1:0] in_instruction,
  input  logic [ADDRESS_WIDTH-1:0]     in_pc,
  output logic [REGISTERNO_WIDTH-1:0]  out_rs1_regno,
  output logic [REGISTERNO_WIDTH-1:0]  out_rs2_regno,
  input  logic [REGISTER_WIDTH-1:0]    in_rs1_value,
  input  logic [REGISTER_WIDTH-1:0]    in_rs2_value,
  input  logic                         in_wb_enable,
  input  logic [REGISTERNO_WIDTH-1:0]  in_wb_regno,
  input  logic [REGISTER_WIDTH-1:0]    in_wb_value,
  input  logic                         in_ex_ready,
  output logic                         out_valid,
  output logic [ADDRESS_WIDTH-1:0]     out_pc,
  output logic [REGISTER_WIDTH-1:0]    out_rs1_value,
  output logic [REGISTER_WIDTH-1:0]    out_rs2_value,
  output logic [REGISTER_WIDTH-1:0]    out_imm,
  output logic [REGISTERNO_WIDTH-1:0]  out_rd_regno,
  output logic [6:0]                   out_opcode,
  output logic [2:0]                   out_funct3,
  output logic [6:0]                   out_funct7,
  output logic                         out_writes_rd,
  output logic                         out_illegal
);

  localparam int NREGS = 1 << REGISTERNO_WIDTH;

  logic [6:0]                  w_opcode;
  logic [2:0]                  w_funct3;
  logic [6:0]                  w_funct7;
  logic [REGISTERNO_WIDTH-1:0] w_rs1, w_rs2, w_rd;
  logic w_is_r, w_is_i, w_is_s, w_is_b, w_is_u, w_is_j, w_illegal;
  logic w_uses_rs1, w_uses_rs2, w_writes_rd;
  logic [REGISTER_WIDTH-1:0]   w_imm;
  logic [REGISTER_WIDTH-1:0]   w_rs1_value, w_rs2_value;
  logic [NREGS-1:0]            w_wb_clear, w_busy_eff, w_set, w_sb_next;
  logic w_hazard, w_advance, w_accept;

  logic [NREGS-1:0]            r_scoreboard;
  logic                        r_valid;
  logic [ADDRESS_WIDTH-1:0]    r_pc;
  logic [REGISTER_WIDTH-1:0]   r_rs1_value, r_rs2_value, r_imm;
  logic [REGISTERNO_WIDTH-1:0] r_rd;
  logic [6:0]                  r_opcode, r_funct7;
  logic [2:0]                  r_funct3;
  logic                        r_writes_rd, r_illegal;

  assign w_opcode = in_instruction[6:0];
  assign w_rd     = in_instruction[11:7];
  assign w_funct3 = in_instruction[14:12];
  assign w_rs1    = in_instruction[19:15];
  assign w_rs2    = in_instruction[24:20];
  assign w_funct7 = in_instruction[31:25];

  assign w_is_r = (w_opcode == 7'b0110011) || (w_opcode == 7'b0111011);
  assign w_is_i = (w_opcode == 7'b0010011) || (w_opcode == 7'b0011011) ||
                  (w_opcode == 7'b0000011) || (w_opcode == 7'b1100111);
  assign w_is_s = (w_opcode == 7'b0100011);
  assign w_is_b = (w_opcode == 7'b1100011);
  assign w_is_u = (w_opcode == 7'b0110111) || (w_opcode == 7'b0010111);
  assign w_is_j = (w_opcode == 7'b1101111);
  assign w_illegal = !(w_is_r || w_is_i || w_is_s || w_is_b || w_is_u || w_is_j);

  assign w_uses_rs1  = w_is_r || w_is_i || w_is_s || w_is_b;
  assign w_uses_rs2  = w_is_r || w_is_s || w_is_b;
  assign w_writes_rd = (w_is_r || w_is_i || w_is_u || w_is_j) && (w_rd != '0);

  always_comb begin
    w_imm = '0;
    if (w_is_i)
      w_imm = {{(REGISTER_WIDTH-12){in_instruction[31]}}, in_instruction[31:20]};
    else if (w_is_s)
      w_imm = {{(REGISTER_WIDTH-12){in_instruction[31]}}, in_instruction[31:25],
               in_instruction[11:7]};
    else if (w_is_b)
      w_imm = {{(REGISTER_WIDTH-13){in_instruction[31]}}, in_instruction[31],
               in_instruction[7], in_instruction[30:25], in_instruction[11:8], 1'b0};
    else if (w_is_u)
      w_imm = {{(REGISTER_WIDTH-32){in_instruction[31]}}, in_instruction[31:12], 12'b0};
    else if (w_is_j)
      w_imm = {{(REGISTER_WIDTH-21){in_instruction[31]}}, in_instruction[31],
               in_instruction[19:12], in_instruction[20], in_instruction[30:21], 1'b0};
  end

  // The register file does not hardwire x0, so zero it here before forwarding.
  assign w_rs1_value = (w_rs1 == '0) ? '0 :
                       (in_wb_enable && in_wb_regno == w_rs1) ? in_wb_value : in_rs1_value;
  assign w_rs2_value = (w_rs2 == '0) ? '0 :
                       (in_wb_enable && in_wb_regno == w_rs2) ? in_wb_value : in_rs2_value;

  assign w_wb_clear = in_wb_enable ? ({{(NREGS-1){1'b0}}, 1'b1} << in_wb_regno) : '0;
  assign w_busy_eff = r_scoreboard & ~w_wb_clear;

  assign w_hazard = (w_uses_rs1  && w_busy_eff[w_rs1]) ||
                    (w_uses_rs2  && w_busy_eff[w_rs2]) ||
                    (w_writes_rd && w_busy_eff[w_rd]);

  assign w_advance = !r_valid || in_ex_ready;
  assign out_ready = w_advance && !w_hazard;
  assign w_accept  = in_valid && out_ready;

  // Set is applied after clear so a new writer wins over a retiring one.
  assign w_set     = (w_accept && w_writes_rd) ? ({{(NREGS-1){1'b0}}, 1'b1} << w_rd) : '0;
  assign w_sb_next = w_busy_eff | w_set;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_scoreboard <= '0;
      r_valid      <= 1'b0;
      r_pc         <= '0;
      r_rs1_value  <= '0;
      r_rs2_value  <= '0;
      r_imm        <= '0;
      r_rd         <= '0;
      r_opcode     <= '0;
      r_funct3     <= '0;
      r_funct7     <= '0;
      r_writes_rd  <= 1'b0;
      r_illegal    <= 1'b0;
    end else begin
      r_scoreboard <= w_sb_next;
      if (w_accept) begin
        r_valid     <= 1'b1;
        r_pc        <= in_pc;
        r_rs1_value <= w_rs1_value;
        r_rs2_value <= w_rs2_value;
        r_imm       <= w_imm;
        r_rd        <= w_rd;
        r_opcode    <= w_opcode;
        r_funct3    <= w_funct3;
        r_funct7    <= w_funct7;
        r_writes_rd <= w_writes_rd;
        r_illegal   <= w_illegal;
      end else if (w_advance) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_rs1_regno = w_rs1;
  assign out_rs2_regno = w_rs2;
  assign out_valid     = r_valid;
  assign out_pc        = r_pc;
  assign out_rs1_value = r_rs1_value;
  assign out_rs2_value = r_rs2_value;
  assign out_imm       = r_imm;
  assign out_rd_regno  = r_rd;
  assign out_opcode    = r_opcode;
  assign out_funct3    = r_funct3;
  assign out_funct7    = r_funct7;
  assign out_writes_rd = r_writes_rd;
  assign out_illegal   = r_illegal;

endmodule

// File: tb/tb_decode_regread_stage.sv
// Bench for decode_regread_stage: directed scenarios then random traffic, checked
// against a behavioural model through an expected-bundle queue.
module tb_decode_regread_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready;
  logic [31:0] in_instruction = '0;
  logic [63:0] in_pc = '0;
  logic [4:0]  out_rs1_regno, out_rs2_regno;
  logic [63:0] in_rs1_value, in_rs2_value;
  logic        in_wb_enable = 1'b0;
  logic [4:0]  in_wb_regno = '0;
  logic [63:0] in_wb_value = '0;
  logic        in_ex_ready = 1'b0;
  logic        out_valid;
  logic [63:0] out_pc, out_rs1_value, out_rs2_value, out_imm;
  logic [4:0]  out_rd_regno;
  logic [6:0]  out_opcode, out_funct7;
  logic [2:0]  out_funct3;
  logic        out_writes_rd, out_illegal;

  always #5 clk = ~clk;

  decode_regread_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .out_ready(out_ready),
    .in_instruction(in_instruction), .in_pc(in_pc),
    .out_rs1_regno(out_rs1_regno), .out_rs2_regno(out_rs2_regno),
    .in_rs1_value(in_rs1_value), .in_rs2_value(in_rs2_value),
    .in_wb_enable(in_wb_enable), .in_wb_regno(in_wb_regno), .in_wb_value(in_wb_value),
    .in_ex_ready(in_ex_ready), .out_valid(out_valid), .out_pc(out_pc),
    .out_rs1_value(out_rs1_value), .out_rs2_value(out_rs2_value), .out_imm(out_imm),
    .out_rd_regno(out_rd_regno), .out_opcode(out_opcode), .out_funct3(out_funct3),
    .out_funct7(out_funct7), .out_writes_rd(out_writes_rd), .out_illegal(out_illegal)
  );

  // Register file model, read combinationally by the stage.
  logic [63:0] rf [32];
  assign in_rs1_value = rf[out_rs1_regno];
  assign in_rs2_value = rf[out_rs2_regno];

  typedef struct packed {
    logic [63:0] pc, rs1v, rs2v, imm;
    logic [4:0]  rd;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        wr, ill;
  } bundle_t;

  bundle_t exp_q[$];
  bit      m_busy [32];
  bit      m_valid = 1'b0;
  bit      mon_en = 1'b0;
  int      checks = 0;
  int      errors = 0;
  int      txn = 0;

  localparam int C_R = 0, C_I = 1, C_S = 2, C_B = 3, C_U = 4, C_J = 5, C_X = 6;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic int cls_of(input logic [6:0] op);
    case (op)
      7'h33, 7'h3B:               return C_R;
      7'h13, 7'h1B, 7'h03, 7'h67: return C_I;
      7'h23:                      return C_S;
      7'h63:                      return C_B;
      7'h37, 7'h17:               return C_U;
      7'h6F:                      return C_J;
      default:                    return C_X;
    endcase
  endfunction

  // Immediate value as a signed number, then seen as 64 bits.
  function automatic logic [63:0] imm_of(input logic [31:0] inst);
    longint v;
    v = 0;
    case (cls_of(inst[6:0]))
      C_I: begin v = inst[31:20]; if (v >= 2048) v -= 4096; end
      C_S: begin v = {inst[31:25], inst[11:7]}; if (v >= 2048) v -= 4096; end
      C_B: begin
        v = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
        if (v >= 4096) v -= 8192;
      end
      C_U: begin v = inst[31:12]; v = v * 4096; if (inst[31]) v -= 64'sh1_0000_0000; end
      C_J: begin
        v = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
        if (v >= 1048576) v -= 2097152;
      end
      default: v = 0;
    endcase
    return v;
  endfunction

  function automatic logic [63:0] operand(input logic [4:0] r, input bit wbe,
                                          input logic [4:0] wbr, input logic [63:0] wbv);
    if (r == 0) return 64'd0;
    if (wbe && wbr == r) return wbv;
    return rf[r];
  endfunction

  // One clock of stimulus; returns the out_ready seen mid-cycle.
  task automatic drive(input bit rst, input bit v, input logic [31:0] inst,
                       input logic [63:0] pc, input bit wbe, input logic [4:0] wbr,
                       input logic [63:0] wbv, input bit exr, output bit rdy);
    bundle_t e;
    bit acc, hz, er, u1, u2, wr;
    int c;
    reset = rst; in_valid = v; in_instruction = inst; in_pc = pc;
    in_wb_enable = wbe; in_wb_regno = wbr; in_wb_value = wbv; in_ex_ready = exr;
    #1;
    rdy = out_ready;
    acc = 1'b0;
    e = '0;
    if (!rst) begin
      c  = cls_of(inst[6:0]);
      u1 = (c == C_R || c == C_I || c == C_S || c == C_B);
      u2 = (c == C_R || c == C_S || c == C_B);
      wr = (c == C_R || c == C_I || c == C_U || c == C_J) && inst[11:7] != 0;
      hz = (u1 && m_busy[inst[19:15]] && !(wbe && wbr == inst[19:15])) ||
           (u2 && m_busy[inst[24:20]] && !(wbe && wbr == inst[24:20])) ||
           (wr && m_busy[inst[11:7]]  && !(wbe && wbr == inst[11:7]));
      er = (!m_valid || exr) && !hz;
      chk("out_ready", out_ready, er);
      chk("rs1_regno", out_rs1_regno, inst[19:15]);
      chk("rs2_regno", out_rs2_regno, inst[24:20]);
      acc = v && er;
      e.pc = pc; e.imm = imm_of(inst); e.rd = inst[11:7]; e.op = inst[6:0];
      e.f3 = inst[14:12]; e.f7 = inst[31:25]; e.wr = wr; e.ill = (c == C_X);
      e.rs1v = operand(inst[19:15], wbe, wbr, wbv);
      e.rs2v = operand(inst[24:20], wbe, wbr, wbv);
    end
    @(posedge clk);
    if (rst) begin
      foreach (m_busy[i]) m_busy[i] = 1'b0;
      m_valid = 1'b0;
      exp_q.delete();
    end else begin
      if (wbe) m_busy[wbr] = 1'b0;
      if (acc && e.wr) m_busy[e.rd] = 1'b1;
      if (!m_valid || exr) m_valid = acc;
      if (acc) exp_q.push_back(e);
    end
    #1;
    if (wbe) rf[wbr] = wbv;
  endtask

  // Monitor: consumes the expected queue whenever execute takes a bundle.
  initial begin
    bundle_t e;
    forever begin
      @(negedge clk);
      if (mon_en && !reset) begin
        chk("out_valid", out_valid, exp_q.size() != 0);
        if (out_valid && in_ex_ready && exp_q.size() > 0) begin
          e = exp_q.pop_front();
          txn++;
          chk("b_pc", out_pc, e.pc);
          chk("b_rs1", out_rs1_value, e.rs1v);
          chk("b_rs2", out_rs2_value, e.rs2v);
          chk("b_imm", out_imm, e.imm);
          chk("b_rd", out_rd_regno, e.rd);
          chk("b_op", out_opcode, e.op);
          chk("b_f3", out_funct3, e.f3);
          chk("b_f7", out_funct7, e.f7);
          chk("b_wr", out_writes_rd, e.wr);
          chk("b_ill", out_illegal, e.ill);
          $display("txn %0d pc=%h op=%h rd=%0d imm=%h rs1=%h rs2=%h", txn, out_pc,
                   out_opcode, out_rd_regno, out_imm, out_rs1_value, out_rs2_value);
        end
      end
    end
  end

  logic [6:0] ops [12] = '{7'h33, 7'h3B, 7'h13, 7'h1B, 7'h03, 7'h67, 7'h23, 7'h63,
                           7'h37, 7'h17, 7'h6F, 7'h7F};

  initial begin
    bit rdy;
    logic [63:0] pc_hold;
    logic [31:0] inst;
    int busy_list[$];
    bit wbe;
    logic [4:0] wbr;

    foreach (rf[i]) rf[i] = {$urandom, $urandom};
    rf[0] = 64'hBAD0_0000_0000_0BAD;
    rf[5] = 64'hDEAD;

    drive(1, 0, 0, 0, 0, 0, 0, 0, rdy);
    drive(1, 0, 0, 0, 0, 0, 0, 0, rdy);
    mon_en = 1'b1;
    chk("reset_valid", out_valid, 0);
    chk("reset_imm", out_imm, 0);
    chk("reset_pc", out_pc, 0);

    // addi x5,x0,7
    drive(0, 1, 32'h00700293, 64'h100, 0, 0, 0, 1, rdy);
    chk("addi_ready", rdy, 1);
    chk("addi_valid", out_valid, 1);
    chk("addi_imm", out_imm, 7);
    chk("addi_rs1", out_rs1_value, 0);
    chk("addi_rd", out_rd_regno, 5);
    chk("addi_wr", out_writes_rd, 1);

    // add x6,x5,x5 stalls on x5, then accepts with the forwarded writeback
    drive(0, 1, 32'h00528333, 64'h104, 0, 0, 0, 1, rdy);
    chk("add_stall", rdy, 0);
    drive(0, 1, 32'h00528333, 64'h104, 1, 5, 64'd7, 1, rdy);
    chk("add_fwd_ready", rdy, 1);
    chk("add_fwd_rs1", out_rs1_value, 7);
    chk("add_fwd_rs2", out_rs2_value, 7);

    // execute stalls for 3 cycles: bundle must hold
    pc_hold = out_pc;
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 32'h00100493, 64'h108, 0, 0, 0, 0, rdy);
      chk("exstall_ready", rdy, 0);
      chk("exstall_valid", out_valid, 1);
      chk("exstall_pc", out_pc, pc_hold);
    end
    drive(0, 1, 32'h00100493, 64'h108, 0, 0, 0, 1, rdy);
    chk("drain_pc", out_pc, 64'h108);
    drive(0, 0, 32'h0, 64'h0, 0, 0, 0, 1, rdy);
    chk("drain_empty", out_valid, 0);

    // immediates: sw x2,8(x1); beq x0,x0,-4; lui x10,0x12345; jal x1,2048
    drive(0, 1, 32'h0020A423, 64'h200, 0, 0, 0, 1, rdy);
    chk("sw_imm", out_imm, 64'd8);
    drive(0, 1, 32'hFE000EE3, 64'h204, 0, 0, 0, 1, rdy);
    chk("beq_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFC);
    drive(0, 1, 32'h12345537, 64'h208, 0, 0, 0, 1, rdy);
    chk("lui_imm", out_imm, 64'h12345000);
    drive(0, 1, 32'h001000EF, 64'h20C, 0, 0, 0, 1, rdy);
    chk("jal_imm", out_imm, 64'h800);

    // x7: set wins over same-cycle clear, then WAW stalls until x7 retires
    drive(0, 1, 32'h00100393, 64'h300, 0, 0, 0, 1, rdy);
    drive(0, 1, 32'h00200393, 64'h304, 1, 7, 64'h11, 1, rdy);
    chk("x7_setwins_ready", rdy, 1);
    drive(0, 1, 32'h00300393, 64'h308, 0, 0, 0, 1, rdy);
    chk("x7_waw_stall", rdy, 0);
    drive(0, 1, 32'h00300393, 64'h308, 1, 7, 64'h22, 1, rdy);
    chk("x7_waw_release", rdy, 1);

    // illegal opcode flows without stalling or writing
    drive(0, 1, 32'h0000007F, 64'h400, 0, 0, 0, 1, rdy);
    chk("ill_ready", rdy, 1);
    chk("ill_flag", out_illegal, 1);
    chk("ill_wr", out_writes_rd, 0);

    // reset asserted in the middle of a WAW stall on x8
    drive(0, 1, 32'h00100413, 64'h500, 0, 0, 0, 1, rdy);
    drive(0, 1, 32'h00100413, 64'h504, 0, 0, 0, 1, rdy);
    chk("x8_stall", rdy, 0);
    drive(1, 1, 32'h00100413, 64'h504, 0, 0, 0, 0, rdy);
    chk("rst_mid_valid", out_valid, 0);
    drive(0, 1, 32'h00100413, 64'h504, 0, 0, 0, 1, rdy);
    chk("rst_mid_ready", rdy, 1);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      inst = {$urandom} & 32'hFE0F_F07F;
      inst[6:0]   = ops[$urandom_range(0, 11)];
      inst[11:7]  = 5'($urandom_range(0, 7));
      inst[19:15] = 5'($urandom_range(0, 7));
      inst[24:20] = 5'($urandom_range(0, 7));
      busy_list.delete();
      for (int r = 1; r < 32; r++) if (m_busy[r]) busy_list.push_back(r);
      wbe = 1'b0;
      wbr = '0;
      if (busy_list.size() > 0 && $urandom_range(0, 1) == 1) begin
        wbe = 1'b1;
        wbr = 5'(busy_list[$urandom_range(0, busy_list.size() - 1)]);
      end else if ($urandom_range(0, 3) == 0) begin
        wbe = 1'b1;
        wbr = 5'($urandom_range(0, 7));
      end
      drive(0, $urandom_range(0, 3) != 0, inst, {32'd0, $urandom},
            wbe, wbr, {$urandom, $urandom}, $urandom_range(0, 3) != 0, rdy);
    end

    for (int k = 0; k < 4; k++) drive(0, 0, 32'h0, 64'h0, 0, 0, 0, 1, rdy);
    chk("final_queue_empty", exp_q.size(), 0);
    chk("final_valid", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_regread_stage.md
Name: decode_regread_stage

Overview:
- Decode/register-read pipeline stage sitting directly upstream of the 32x64 register file.
- Decodes the RV64I instruction and drives the register-file read addresses, and samples the returned operands.
- Tracks pending writes in a scoreboard and stalls on hazards.
- Forwards the same-cycle writeback value, then registers a decoded bundle toward execute using a valid/ready handshake.

Parameters:
- ADDRESS_WIDTH, 64, PC width.
- REGISTER_WIDTH, 64, operand and immediate width.
- REGISTERNO_WIDTH, 5, register index width.
- INSTRUCTION_WIDTH, 32, instruction width.

Ports:
- clk  input  1  clock, all state updates on posedge.
- reset  input  1  synchronous, active-high.
- in_valid  input  1  fetch presents an instruction.
- out_ready  output  1  stage accepts the fetch instruction this cycle.
- in_instruction  input  INSTRUCTION_WIDTH  raw instruction.
- in_pc  input  ADDRESS_WIDTH  instruction PC.
- out_rs1_regno  output  REGISTERNO_WIDTH  register-file read address 1, equal to in_instruction[19:15].
- out_rs2_regno  output  REGISTERNO_WIDTH  register-file read address 2, equal to in_instruction[24:20].
- in_rs1_value  input  REGISTER_WIDTH  register-file read data 1 (combinational).
- in_rs2_value  input  REGISTER_WIDTH  register-file read data 2 (combinational).
- in_wb_enable  input  1  writeback commits this cycle.
- in_wb_regno  input  REGISTERNO_WIDTH  writeback destination.
- in_wb_value  input  REGISTER_WIDTH  writeback data.
- in_ex_ready  input  1  execute accepts the bundle.
- out_valid  output  1  bundle valid.
- out_pc  output  ADDRESS_WIDTH  bundle PC.
- out_rs1_value  output  REGISTER_WIDTH  operand 1.
- out_rs2_value  output  REGISTER_WIDTH  operand 2.
- out_imm  output  REGISTER_WIDTH  sign-extended immediate.
- out_rd_regno  output  REGISTERNO_WIDTH  destination register.
- out_opcode  output  7  opcode field.
- out_funct3  output  3  funct3 field.
- out_funct7  output  7  funct7 field.
- out_writes_rd  output  1  instruction writes a nonzero rd.
- out_illegal  output  1  opcode not recognised.

Behaviour:
- Reset (synchronous):
  - out_valid=0.
  - All bundle outputs = 0.
  - Scoreboard (32 bits) cleared.
  - Reset overrides everything in the same cycle, including a mid-stall state and a pending wb.
- Opcode classes:
  - R: 0110011, 0111011
  - I: 0010011, 0011011, 0000011, 1100111
  - S: 0100011
  - B: 1100011
  - U: 0110111, 0010111
  - J: 1101111
  - Anything else: out_illegal=1, no source use, no rd write.
- Immediates (sign-extended to REGISTER_WIDTH):
  - I: inst[31:20].
  - S: {inst[31:25], inst[11:7]}.
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - U: {inst[31:12], 12'b0}.
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - R and illegal: 0.
- Source and destination use:
  - uses_rs1: R, I, S, B.
  - uses_rs2: R, S, B.
  - writes_rd: R, I, U, J, and only when rd!=0.
- Operand selection, per source, in priority order:
  1. regno==0 -> 0. The register file does not hardwire x0.
  2. Otherwise, in_wb_enable && in_wb_regno==regno -> in_wb_value (forward).
  3. Otherwise -> register-file value.
- Hazard: hazard=1 if any of the following holds. A busy bit being cleared by in_wb this cycle does not count as busy.
  - uses_rs1 and scoreboard[rs1] busy (RAW).
  - uses_rs2 and scoreboard[rs2] busy (RAW).
  - writes_rd and scoreboard[rd] busy (WAW).
- Handshake:
  - advance = !out_valid || in_ex_ready.
  - out_ready = advance && !hazard. out_ready is combinational and independent of in_valid.
  - accept = in_valid && out_ready.
  - On accept: the bundle registers load, and out_valid=1 next cycle. Latency is 1 cycle.
  - On advance without accept: out_valid<=0.
  - When !advance: the bundle holds stable.
- Scoreboard:
  - Each cycle, in_wb_enable clears bit in_wb_regno.
  - An accept with writes_rd sets bit rd.
  - If set and clear hit the same index in one cycle, set wins.
  - Bit 0 is never set.
- Illegal instructions still flow downstream with out_illegal=1 and out_writes_rd=0.

Test Plan:
- Reset, then accept `addi x5,x0,7` (0x00700293, pc 0x100) -> the next cycle shows out_valid=1, imm=7, rs1_value=0, rd=5, writes_rd=1, and scoreboard[5] is set.
- Follow with `add x6,x5,x5` while x5 is busy -> out_ready=0. Then pulse wb x5=7 -> accept in that same cycle, and the next cycle's rs1_value=rs2_value=7 (forwarded).
- Hold in_ex_ready=0 for 3 cycles with a valid bundle -> the bundle stays stable, out_ready=0, and out_valid stays 1. Deasserting stall with ex_ready=1 drains the bundle one per cycle.
- Decode immediates for sw, beq (offset -4), lui 0x12345, and jal (offset 2048):
  - S imm matches.
  - beq out_imm=0xFFFF_FFFF_FFFF_FFFC.
  - lui out_imm=0x12345000.
  - jal out_imm=0x800.
- Issue `addi x7` in the same cycle that wb x7 retires an older write -> scoreboard[7] remains 1. A second writer to x7 (WAW) stalls until x7's wb.
- Opcode 0x7F -> out_illegal=1, writes_rd=0, no stall. Assert reset mid-stall -> out_valid=0, the scoreboard clears, and out_ready=1 the next cycle.
